// File: rtl/br_resolve_unit_if.sv
// Condition-code, branch-request and redirect signals between the datapath and br_resolve_unit.
interface br_resolve_unit_if #(
  parameter int PC_W = 16
);
  logic            cc_ld;
  logic [PC_W-1:0] cc_bus;
  logic            cc_pend_inc;
  logic            cc_pend_full;
  logic            br_valid;
  logic            br_ready;
  logic [PC_W-1:0] br_ir;
  logic [PC_W-1:0] br_pc;
  logic            redir_valid;
  logic            redir_ready;
  logic            redir_taken;
  logic [PC_W-1:0] redir_pc;
  logic [2:0]      nzp;

  modport master (
    output cc_ld, cc_bus, cc_pend_inc, br_valid, br_ir, br_pc, redir_ready,
    input  cc_pend_full, br_ready, redir_valid, redir_taken, redir_pc, nzp
  );

  modport slave (
    input  cc_ld, cc_bus, cc_pend_inc, br_valid, br_ir, br_pc, redir_ready,
    output cc_pend_full, br_ready, redir_valid, redir_taken, redir_pc, nzp
  );
endinterface

// File: rtl/br_resolve_unit.sv
// LC-3 branch resolution: NZP register, pending CC-writer tracking and registered PC redirect.
// Optional macro BR_CC_BYPASS_EN: resolve straight from the final cc_bus write, skipping EVAL.
module br_resolve_unit #(
  parameter int PC_W     = 16,
  parameter int MAX_PEND = 3
) (
  input logic            Clk,
  input logic            Reset_n,
  br_resolve_unit_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_PEND + 1);

  typedef enum logic [1:0] {IDLE, WAIT_CC, EVAL, ISSUE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  pend_reg, pend_next;
  logic [2:0]        nzp_reg, bus_nzp, cond_reg, eval_nzp;
  logic [PC_W-1:0]   target_reg, pc_reg, redir_pc_reg, br_target;
  logic              redir_taken_reg;
  logic              pend_full, accept, resolve;
  logic              unused_ir;

  assign unused_ir = ^bus.br_ir[PC_W-1:12];
  assign br_target = bus.br_pc + {{(PC_W-9){bus.br_ir[8]}}, bus.br_ir[8:0]};
  assign pend_full = (pend_reg == CNT_W'(MAX_PEND));

  always_comb begin
    bus_nzp = 3'b001;
    if (bus.cc_bus[PC_W-1])
      bus_nzp = 3'b100;
    else if (bus.cc_bus == '0)
      bus_nzp = 3'b010;
  end

  // Simultaneous issue and retire cancel; saturate at both ends.
  always_comb begin
    pend_next = pend_reg;
    if (bus.cc_pend_inc && !bus.cc_ld) begin
      if (!pend_full)
        pend_next = pend_reg + CNT_W'(1);
    end else if (bus.cc_ld && !bus.cc_pend_inc) begin
      if (pend_reg != '0)
        pend_next = pend_reg - CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    resolve    = 1'b0;
    eval_nzp   = nzp_reg;
    case (state_reg)
      IDLE: begin
        if (bus.br_valid) begin
          accept     = 1'b1;
          state_next = (pend_next == '0) ? EVAL : WAIT_CC;
        end
      end
      WAIT_CC: begin
        if (pend_next == '0) begin
`ifdef BR_CC_BYPASS_EN
          if (bus.cc_ld) begin
            resolve    = 1'b1;
            eval_nzp   = bus_nzp;
            state_next = ISSUE;
          end else begin
            state_next = EVAL;
          end
`else
          state_next = EVAL;
`endif
        end
      end
      EVAL: begin
        resolve    = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        if (bus.redir_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg       <= IDLE;
      pend_reg        <= '0;
      nzp_reg         <= 3'b010;
      cond_reg        <= '0;
      target_reg      <= '0;
      pc_reg          <= '0;
      redir_taken_reg <= 1'b0;
      redir_pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      if (bus.cc_ld)
        nzp_reg <= bus_nzp;
      if (accept) begin
        cond_reg   <= bus.br_ir[11:9];
        target_reg <= br_target;
        pc_reg     <= bus.br_pc;
      end
      if (resolve) begin
        redir_taken_reg <= |(cond_reg & eval_nzp);
        redir_pc_reg    <= (|(cond_reg & eval_nzp)) ? target_reg : pc_reg;
      end
    end
  end

  assign bus.br_ready     = (state_reg == IDLE);
  assign bus.redir_valid  = (state_reg == ISSUE);
  assign bus.redir_taken  = redir_taken_reg;
  assign bus.redir_pc     = redir_pc_reg;
  assign bus.nzp          = nzp_reg;
  assign bus.cc_pend_full = pend_full;
endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit: vector table plus stall, backpressure and counter sequences.
module tb_br_resolve_unit;
  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;

  br_resolve_unit_if #(.PC_W(16)) bif ();

  br_resolve_unit #(.PC_W(16), .MAX_PEND(3)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bif.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        do_load;
    logic [15:0] bus_val;
    logic [2:0]  exp_nzp;
    logic [2:0]  mask;
    logic [8:0]  off;
    logic [15:0] pc;
    logic        exp_taken;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs [8];

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_cc(input logic [15:0] v);
    bif.cc_ld  = 1'b1;
    bif.cc_bus = v;
    tick();
    bif.cc_ld  = 1'b0;
  endtask

  // Unstalled branch: accept in cycle 0, EVAL in cycle 1, redirect in cycle 2.
  task automatic do_branch(input string name, input logic [2:0] mask, input logic [8:0] off,
                           input logic [15:0] pc, input logic exp_taken, input logic [15:0] exp_pc);
    bif.br_valid = 1'b1;
    bif.br_ir    = {4'b0000, mask, off};
    bif.br_pc    = pc;
    chk({name, ".br_ready"}, 32'(bif.br_ready), 32'd1);
    tick();
    bif.br_valid = 1'b0;
    chk({name, ".valid_c1"}, 32'(bif.redir_valid), 32'd0);
    tick();
    chk({name, ".valid_c2"}, 32'(bif.redir_valid), 32'd1);
    chk({name, ".taken"}, 32'(bif.redir_taken), 32'(exp_taken));
    chk({name, ".pc"}, 32'(bif.redir_pc), 32'(exp_pc));
    $display("branch %s mask=%b off=%h pc=%h -> taken=%b redir_pc=%h", name, mask, off, pc,
             bif.redir_taken, bif.redir_pc);
    bif.redir_ready = 1'b1;
    tick();
    bif.redir_ready = 1'b0;
    chk({name, ".done"}, 32'(bif.redir_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] held_pc;
    logic        held_taken;
    checks = 0;
    errors = 0;
    Reset_n         = 1'b0;
    bif.cc_ld       = 1'b0;
    bif.cc_bus      = '0;
    bif.cc_pend_inc = 1'b0;
    bif.br_valid    = 1'b0;
    bif.br_ir       = '0;
    bif.br_pc       = '0;
    bif.redir_ready = 1'b0;

    vecs[0] = '{1'b0, 16'h0000, 3'b010, 3'b010, 9'h005, 16'h3001, 1'b1, 16'h3006};
    vecs[1] = '{1'b1, 16'h8000, 3'b100, 3'b011, 9'h00A, 16'h3100, 1'b0, 16'h3100};
    vecs[2] = '{1'b1, 16'h0005, 3'b001, 3'b001, 9'h1FF, 16'h1000, 1'b1, 16'h0FFF};
    vecs[3] = '{1'b0, 16'h0000, 3'b001, 3'b110, 9'h004, 16'h1200, 1'b0, 16'h1200};
    vecs[4] = '{1'b1, 16'h0000, 3'b010, 3'b111, 9'h1FC, 16'h0002, 1'b1, 16'hFFFE};
    vecs[5] = '{1'b0, 16'h0000, 3'b010, 3'b000, 9'h010, 16'h4000, 1'b0, 16'h4000};
    vecs[6] = '{1'b1, 16'hFFFF, 3'b100, 3'b100, 9'h100, 16'h0100, 1'b1, 16'h0000};
    vecs[7] = '{1'b1, 16'h7FFF, 3'b001, 3'b110, 9'h0FF, 16'h2000, 1'b0, 16'h2000};

    tick();
    chk("rst.nzp", 32'(bif.nzp), 32'b010);
    chk("rst.redir_valid", 32'(bif.redir_valid), 32'd0);
    chk("rst.br_ready", 32'(bif.br_ready), 32'd1);
    chk("rst.full", 32'(bif.cc_pend_full), 32'd0);
    chk("rst.taken", 32'(bif.redir_taken), 32'd0);
    chk("rst.pc", 32'(bif.redir_pc), 32'd0);
    Reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_load) begin
        load_cc(vecs[i].bus_val);
        chk($sformatf("v%0d.nzp", i), 32'(bif.nzp), 32'(vecs[i].exp_nzp));
      end
      do_branch($sformatf("v%0d", i), vecs[i].mask, vecs[i].off, vecs[i].pc,
                vecs[i].exp_taken, vecs[i].exp_pc);
    end

    // Stall on two outstanding writers; only the second retire releases the branch.
    bif.cc_pend_inc = 1'b1;
    tick();
    tick();
    bif.cc_pend_inc = 1'b0;
    bif.br_valid = 1'b1;
    bif.br_ir    = {4'b0000, 3'b001, 9'h003};
    bif.br_pc    = 16'h3000;
    tick();
    bif.br_valid = 1'b0;
    chk("stall.br_ready", 32'(bif.br_ready), 32'd0);
    tick();
    chk("stall.wait", 32'(bif.redir_valid), 32'd0);
    load_cc(16'h0000);
    chk("stall.nzp1", 32'(bif.nzp), 32'b010);
    chk("stall.after_ld1", 32'(bif.redir_valid), 32'd0);
    load_cc(16'h0007);
    chk("stall.nzp2", 32'(bif.nzp), 32'b001);
`ifndef BR_CC_BYPASS_EN
    chk("stall.eval_cycle", 32'(bif.redir_valid), 32'd0);
    tick();
`endif
    chk("stall.valid", 32'(bif.redir_valid), 32'd1);
    chk("stall.taken", 32'(bif.redir_taken), 32'd1);
    chk("stall.pc", 32'(bif.redir_pc), 32'h3003);
    $display("stall branch -> taken=%b redir_pc=%h", bif.redir_taken, bif.redir_pc);

    // Backpressure: redirect holds while a competing branch is offered.
    held_pc    = 16'h3003;
    held_taken = 1'b1;
    bif.br_valid = 1'b1;
    bif.br_ir    = {4'b0000, 3'b111, 9'h040};
    bif.br_pc    = 16'h6000;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("bp%0d.valid", c), 32'(bif.redir_valid), 32'd1);
      chk($sformatf("bp%0d.pc", c), 32'(bif.redir_pc), 32'(held_pc));
      chk($sformatf("bp%0d.taken", c), 32'(bif.redir_taken), 32'(held_taken));
      chk($sformatf("bp%0d.br_ready", c), 32'(bif.br_ready), 32'd0);
    end
    bif.br_valid    = 1'b0;
    bif.redir_ready = 1'b1;
    tick();
    bif.redir_ready = 1'b0;
    chk("bp.idle_ready", 32'(bif.br_ready), 32'd1);
    tick();
    chk("bp.no_ghost", 32'(bif.redir_valid), 32'd0);
    $display("backpressure released -> br_ready=%b", bif.br_ready);

    // Counter saturation and simultaneous inc/retire.
    bif.cc_pend_inc = 1'b1;
    tick();
    tick();
    chk("cnt.two_full", 32'(bif.cc_pend_full), 32'd0);
    tick();
    chk("cnt.three_full", 32'(bif.cc_pend_full), 32'd1);
    tick();
    chk("cnt.inc_ignored", 32'(bif.cc_pend_full), 32'd1);
    bif.cc_ld = 1'b1;
    tick();
    chk("cnt.inc_ld_hold", 32'(bif.cc_pend_full), 32'd1);
    bif.cc_pend_inc = 1'b0;
    tick();
    chk("cnt.ld_dec", 32'(bif.cc_pend_full), 32'd0);
    tick();
    bif.cc_ld = 1'b0;
    bif.br_valid = 1'b1;
    bif.br_ir    = {4'b0000, 3'b111, 9'h001};
    bif.br_pc    = 16'h7000;
    tick();
    bif.br_valid = 1'b0;
    chk("cnt.one_left_wait", 32'(bif.br_ready), 32'd0);
    tick();
    tick();
    chk("cnt.still_wait", 32'(bif.redir_valid), 32'd0);

    // Asynchronous reset mid-wait drops the branch and clears the count.
    Reset_n = 1'b0;
    #2;
    chk("rstw.br_ready", 32'(bif.br_ready), 32'd1);
    chk("rstw.nzp", 32'(bif.nzp), 32'b010);
    chk("rstw.redir_valid", 32'(bif.redir_valid), 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    do_branch("post_rst", 3'b010, 9'h020, 16'h5000, 1'b1, 16'h5020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/br_resolve_unit.md
# br_resolve_unit

Sequential consumer of the LC-3 condition codes in the datapath. It holds the NZP register, which loads from the bus value written back. It accepts decoded BR instructions over a valid/ready handshake and stalls each branch until every outstanding condition-code writer has retired. It then evaluates the branch enable and presents a registered PC redirect to the fetch stage.

## Interface
- PC_W, 16: width of PC, bus and IR values.
- MAX_PEND, 3: maximum outstanding CC-writing instructions tracked (counter width = clog2(MAX_PEND+1)).

- Clk  in  1  clock, all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- cc_ld  in  1  load NZP from cc_bus this cycle; retires one pending writer.
- cc_bus  in  PC_W  value being written back.
- cc_pend_inc  in  1  a CC-writing instruction was issued.
- cc_pend_full  out  1  pending count == MAX_PEND.
- br_valid  in  1  BR instruction offered.
- br_ready  out  1  unit can accept.
- br_ir  in  PC_W  BR instruction word; [11:9]=n,z,p mask, [8:0]=PCoffset9.
- br_pc  in  PC_W  incremented PC of the BR.
- redir_valid  out  1  redirect available.
- redir_ready  in  1  fetch accepts redirect.
- redir_taken  out  1  branch enable result.
- redir_pc  out  PC_W  next PC: target if taken, else br_pc.
- nzp  out  3  current condition codes {N,Z,P}.

## Operation
- NZP derivation on cc_ld: N=cc_bus[MSB]; Z=(cc_bus==0); P=otherwise. Exactly one bit set.
- Pending counter: +1 on cc_pend_inc, -1 on cc_ld. Both in the same cycle leaves it unchanged. cc_pend_inc when full is ignored, because upstream must stall on cc_pend_full. cc_ld at zero leaves the count at 0 but still loads NZP.
- pend_next is the counter value after this cycle's inc/dec.
- States: IDLE, WAIT_CC, EVAL, ISSUE.
- IDLE: br_ready=1. On br_valid, latch the cond mask and target = br_pc + sext(br_ir[8:0]) (modulo 2^PC_W, wrap allowed), and latch br_pc. Go to EVAL if pend_next==0, else WAIT_CC.
- WAIT_CC: br_ready=0. Go to EVAL when pend_next==0.
- EVAL: register BEN = |(cond & nzp) into redir_taken; register redir_pc. Go to ISSUE.
- ISSUE: redir_valid=1. redir_taken and redir_pc hold stable until redir_ready. On redir_ready go to IDLE; a new branch is not accepted in the same cycle.
- Mask 000 is never taken, so redir_pc=br_pc. Mask 111 is always taken.
- NZP and the pending counter keep updating in every state.

## Timing
- Reset values: state IDLE; nzp=3'b010; pending=0; redir_valid=0; redir_taken=0; redir_pc=0; br_ready=1 (IDLE); cc_pend_full=0.
- Reset_n low at any point, mid-branch included, clears everything immediately. The in-flight branch is dropped.
- cc_ld in cycle t makes nzp visible from t+1.
- No pending writers: accept in cycle 0, EVAL in cycle 1, redir_valid high from cycle 2.
- Pending writers: EVAL occurs in the cycle after the edge on which the last cc_ld retires, so it sees the updated NZP. A cc_ld in the acceptance cycle counts.
- A cc_pend_inc arriving in WAIT_CC extends the wait. One arriving in EVAL/ISSUE does not affect the current branch.

## Configuration
- BR_CC_BYPASS_EN defined: in WAIT_CC, a cycle with cc_ld and pend_next==0 goes directly to ISSUE. redir_taken is computed from the NZP derived from the cc_bus of that cycle, so redir_valid is high one cycle after the final cc_ld. IDLE behaviour is unchanged.
- BR_CC_BYPASS_EN undefined: always via EVAL, so redir_valid is high two cycles after the final cc_ld.

## Test plan
- Reset: Reset_n low → nzp=010, redir_valid=0, br_ready=1. Then BR with mask 010, offset +5, br_pc=0x3001 and no pending → redir_valid in cycle 2, taken=1, redir_pc=0x3006.
- NZP load: cc_ld with cc_bus=0x8000 → nzp=100 next cycle. BR mask 011 → taken=0, redir_pc=br_pc.
- Stall: two cc_pend_inc, accept BR mask 001. cc_ld 0x0000 then cc_ld 0x0007 → redir_valid only after the second load (cycle +2, or +1 with BR_CC_BYPASS_EN), taken=1.
- Backpressure: redir_ready low for 4 cycles → redir_pc/redir_taken stable, br_ready=0, new br_valid ignored.
- Wrap/offset: br_pc=0x0002, offset 0x1FC (−4) mask 111 → redir_pc=0xFFFE. Mask 000 → not taken.
- Counter edges: MAX_PEND incs → cc_pend_full=1, further inc ignored. Simultaneous inc+ld keeps the count. Reset_n pulse in WAIT_CC → IDLE, pending=0.
